// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared definitions for the execute stage.
//   WORD_LEN      datapath width
//   CMD_*         EXE_CMD opcode encodings
//   ST_N..ST_V    bit positions inside the {N,Z,C,V} status register
//   mul_state_e   state of the iterative multiplier
//   exe_mem_t     EXE/MEM pipeline payload
package exe_stage_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic [WORD_LEN-1:0] alu_res;
    logic [WORD_LEN-1:0] st_value;
    logic                mem_r_en;
    logic                mem_w_en;
    logic                wb_en;
    logic [3:0]          dest;
  } exe_mem_t;

endpackage

// File: rtl/exe_stage_seq_mul.sv
// exe_stage_seq_mul: 32-step shift-add multiplier (low 32 bits of product).
//   clk, rst     clock, async active-high reset
//   start        accept a multiply this cycle (only honoured in S_IDLE)
//   mcand_in     multiplicand, sampled on start
//   mplier_in    multiplier, sampled on start
//   busy         combinational stall request to the front end
//   done         high in the cycle of the final step; product valid then
//   product      accumulator after the current step (valid when done)
//   state        FSM state, exported for debug
import exe_stage_pkg::*;

module exe_stage_seq_mul (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_LEN-1:0] mcand_in,
  input  logic [WORD_LEN-1:0] mplier_in,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] product,
  output mul_state_e          state
);

  mul_state_e          state_next;
  logic [4:0]          count;
  logic [WORD_LEN-1:0] acc;
  logic [WORD_LEN-1:0] mcand;
  logic [WORD_LEN-1:0] mplier;
  logic [WORD_LEN-1:0] acc_next;
  logic                last_step;

  assign last_step = (state == S_MUL_RUN) && (count == 5'd31);
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;
  // The final step's sum is forwarded so the product lands in EXE/MEM at
  // the same edge the last step completes.
  assign product   = acc_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start)     state_next = S_MUL_RUN;
      S_MUL_RUN: if (last_step) state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Output logic: busy drops in the last step so the front end can advance
  // on the same edge that writes the product.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE:    busy = start;
      S_MUL_RUN: begin
        busy = !last_step;
        done = last_step;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        count  <= '0;
        acc    <= '0;
        mcand  <= mcand_in;
        mplier <= mplier_in;
      end
    end else begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage. ALU, NZCV status register, EXE/MEM register and
// the iterative multiplier.
//   clk, rst                       clock, async active-high reset
//   flush                          kill the instruction presented this cycle
//   EXE_CMD, S                     opcode, status-update enable
//   MEM_R_EN_in, MEM_W_EN_in,
//   WB_EN_in, Dest_in              ID/EXE control
//   Val1, Val2, ST_value_in        operands and store data
//   ALU_res, ST_value, MEM_R_EN,
//   MEM_W_EN, WB_EN, Dest          registered EXE/MEM payload
//   status                         registered {N,Z,C,V}
//   busy                           combinational stall
//   dbg_state                      multiplier FSM state (debug)
//
// Handshake: there is no valid/ready pair. busy is a stall: while it is high
// the upstream stage must hold EXE_CMD and all operands/controls unchanged;
// the instruction presented in a cycle with busy low is consumed at the edge.
import exe_stage_pkg::*;

module exe_stage (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [3:0]          EXE_CMD,
  input  logic                S,
  input  logic                MEM_R_EN_in,
  input  logic                MEM_W_EN_in,
  input  logic                WB_EN_in,
  input  logic [3:0]          Dest_in,
  input  logic [WORD_LEN-1:0] Val1,
  input  logic [WORD_LEN-1:0] Val2,
  input  logic [WORD_LEN-1:0] ST_value_in,
  output logic [WORD_LEN-1:0] ALU_res,
  output logic [WORD_LEN-1:0] ST_value,
  output logic                MEM_R_EN,
  output logic                MEM_W_EN,
  output logic                WB_EN,
  output logic [3:0]          Dest,
  output logic [3:0]          status,
  output logic                busy,
  output mul_state_e          dbg_state
);

  exe_mem_t            exe_mem_q;
  exe_mem_t            cap_q;      // controls of the multiply in flight
  logic                cap_s_q;
  logic                is_mul;
  logic                accept_mul;
  logic                mul_done;
  logic [WORD_LEN-1:0] mul_product;

  logic [WORD_LEN-1:0] alu_res;
  logic [3:0]          alu_status;
  logic                op_valid;
  logic                is_arith;
  logic [WORD_LEN-1:0] add_b;
  logic                add_cin;
  logic [WORD_LEN:0]   add_full;

  assign is_mul     = (EXE_CMD == CMD_MUL);
  assign accept_mul = (dbg_state == S_IDLE) && is_mul && !flush;

  exe_stage_seq_mul u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_mul),
    .mcand_in  (Val1),
    .mplier_in (Val2),
    .busy      (busy),
    .done      (mul_done),
    .product   (mul_product),
    .state     (dbg_state)
  );

  // Subtraction is Val1 + ~Val2 + cin, so C is the no-borrow flag and V is
  // judged on the operands as actually fed to the adder.
  always_comb begin
    alu_res    = '0;
    alu_status = status;
    op_valid   = 1'b1;
    is_arith   = 1'b0;
    add_b      = Val2;
    add_cin    = 1'b0;
    case (EXE_CMD)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; add_cin = status[ST_C]; end
      CMD_SUB: begin is_arith = 1'b1; add_b = ~Val2; add_cin = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; add_b = ~Val2; add_cin = status[ST_C]; end
      default: ;
    endcase
    add_full = {1'b0, Val1} + {1'b0, add_b} + {{WORD_LEN{1'b0}}, add_cin};
    case (EXE_CMD)
      CMD_MOV: alu_res = Val2;
      CMD_MVN: alu_res = ~Val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res = add_full[WORD_LEN-1:0];
      CMD_AND: alu_res = Val1 & Val2;
      CMD_ORR: alu_res = Val1 | Val2;
      CMD_EOR: alu_res = Val1 ^ Val2;
      default: op_valid = 1'b0;
    endcase
    if (op_valid) begin
      alu_status[ST_N] = alu_res[WORD_LEN-1];
      alu_status[ST_Z] = (alu_res == '0);
      if (is_arith) begin
        alu_status[ST_C] = add_full[WORD_LEN];
        alu_status[ST_V] = (Val1[WORD_LEN-1] == add_b[WORD_LEN-1]) &&
                           (alu_res[WORD_LEN-1] != Val1[WORD_LEN-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_mem_q <= '0;
      cap_q     <= '0;
      cap_s_q   <= 1'b0;
      status    <= '0;
    end else if (dbg_state == S_MUL_RUN) begin
      // Inputs and flush are ignored until the product retires.
      if (mul_done) begin
        exe_mem_q         <= cap_q;
        exe_mem_q.alu_res <= mul_product;
        if (cap_s_q) begin
          status[ST_N] <= mul_product[WORD_LEN-1];
          status[ST_Z] <= (mul_product == '0);
        end
      end else begin
        exe_mem_q <= '0;
      end
    end else if (flush || is_mul) begin
      exe_mem_q <= '0;
      if (accept_mul) begin
        cap_q.alu_res  <= '0;
        cap_q.st_value <= ST_value_in;
        cap_q.mem_r_en <= MEM_R_EN_in;
        cap_q.mem_w_en <= MEM_W_EN_in;
        cap_q.wb_en    <= WB_EN_in;
        cap_q.dest     <= Dest_in;
        cap_s_q        <= S;
      end
    end else begin
      exe_mem_q.alu_res  <= alu_res;
      exe_mem_q.st_value <= ST_value_in;
      exe_mem_q.mem_r_en <= MEM_R_EN_in;
      exe_mem_q.mem_w_en <= MEM_W_EN_in;
      exe_mem_q.wb_en    <= WB_EN_in;
      exe_mem_q.dest     <= Dest_in;
      if (S && op_valid) status <= alu_status;
    end
  end

  assign ALU_res  = exe_mem_q.alu_res;
  assign ST_value = exe_mem_q.st_value;
  assign MEM_R_EN = exe_mem_q.mem_r_en;
  assign MEM_W_EN = exe_mem_q.mem_w_en;
  assign WB_EN    = exe_mem_q.wb_en;
  assign Dest     = exe_mem_q.dest;

endmodule

// File: tb/tb_exe_stage.sv
import exe_stage_pkg::*;

module tb_exe_stage;

  logic                clk;
  logic                rst;
  logic                flush;
  logic [3:0]          EXE_CMD;
  logic                S;
  logic                MEM_R_EN_in;
  logic                MEM_W_EN_in;
  logic                WB_EN_in;
  logic [3:0]          Dest_in;
  logic [WORD_LEN-1:0] Val1;
  logic [WORD_LEN-1:0] Val2;
  logic [WORD_LEN-1:0] ST_value_in;
  logic [WORD_LEN-1:0] ALU_res;
  logic [WORD_LEN-1:0] ST_value;
  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic                WB_EN;
  logic [3:0]          Dest;
  logic [3:0]          status;
  logic                busy;
  mul_state_e          dbg_state;

  int checks = 0;
  int errors = 0;

  exe_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .EXE_CMD     (EXE_CMD),
    .S           (S),
    .MEM_R_EN_in (MEM_R_EN_in),
    .MEM_W_EN_in (MEM_W_EN_in),
    .WB_EN_in    (WB_EN_in),
    .Dest_in     (Dest_in),
    .Val1        (Val1),
    .Val2        (Val2),
    .ST_value_in (ST_value_in),
    .ALU_res     (ALU_res),
    .ST_value    (ST_value),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .WB_EN       (WB_EN),
    .Dest        (Dest),
    .status      (status),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic set_op(input logic [3:0] cmd, input logic s, input logic r,
                        input logic w, input logic wb, input logic [3:0] dst,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] st);
    flush       = 1'b0;
    EXE_CMD     = cmd;
    S           = s;
    MEM_R_EN_in = r;
    MEM_W_EN_in = w;
    WB_EN_in    = wb;
    Dest_in     = dst;
    Val1        = v1;
    Val2        = v2;
    ST_value_in = st;
  endtask

  task automatic set_idle();
    set_op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_op(CMD_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h10, 32'h20, 32'h55);
    next_cycle();
    checks++;
    if (ALU_res !== 32'h30) begin
      errors++; $display("FAIL pre_reset_add: got %h expected %h", ALU_res, 32'h30);
    end
    set_op(CMD_SUB, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32'h1, 32'h2, 32'h66);
    #3 rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if ({ALU_res, ST_value, MEM_R_EN, MEM_W_EN, WB_EN, Dest} !== '0) begin
      errors++; $display("FAIL reset_outputs: got res=%h st=%h r=%b w=%b wb=%b dest=%h expected all zero",
                         ALU_res, ST_value, MEM_R_EN, MEM_W_EN, WB_EN, Dest);
    end
    checks++;
    if (status !== 4'b0000) begin
      errors++; $display("FAIL reset_status: got %b expected 0000", status);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (ALU_res !== '0 || WB_EN !== 1'b0 || status !== 4'b0000) begin
      errors++; $display("FAIL after_release: got res=%h wb=%b status=%b expected 0/0/0000",
                         ALU_res, WB_EN, status);
    end
  endtask

  task automatic test_add_carry();
    set_op(CMD_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1, 32'h0);
    next_cycle();
    checks++;
    if (ALU_res !== 32'h0 || WB_EN !== 1'b1 || Dest !== 4'd3) begin
      errors++; $display("FAIL add_wrap: got res=%h wb=%b dest=%0d expected 0/1/3", ALU_res, WB_EN, Dest);
    end
    checks++;
    if (status !== 4'b0110) begin
      errors++; $display("FAIL add_wrap_status: got %b expected 0110", status);
    end
  endtask

  task automatic test_sub_sbc();
    set_op(CMD_SUB, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 32'd5, 32'd7, 32'h0);
    next_cycle();
    checks++;
    if (ALU_res !== 32'hFFFF_FFFE || status !== 4'b1000) begin
      errors++; $display("FAIL sub_borrow: got res=%h nzcv=%b expected fffffffe/1000", ALU_res, status);
    end
    set_op(CMD_SBC, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 32'd10, 32'd3, 32'h0);
    next_cycle();
    checks++;
    if (ALU_res !== 32'd6 || status !== 4'b0010) begin
      errors++; $display("FAIL sbc_with_c0: got res=%h nzcv=%b expected 00000006/0010", ALU_res, status);
    end
  endtask

  task automatic test_logic();
    // Status entering: 0001 (V set by the overflow before the multiply).
    set_op(CMD_EOR, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 32'hF0F0, 32'hF0F0, 32'h0);
    next_cycle();
    checks++;
    if (ALU_res !== 32'h0 || status !== 4'b0101) begin
      errors++; $display("FAIL eor_zero: got res=%h nzcv=%b expected 0/0101", ALU_res, status);
    end
    set_op(CMD_MVN, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 32'h0, 32'h0, 32'h0);
    next_cycle();
    checks++;
    if (ALU_res !== 32'hFFFF_FFFF || status !== 4'b1001) begin
      errors++; $display("FAIL mvn: got res=%h nzcv=%b expected ffffffff/1001", ALU_res, status);
    end
    set_op(4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h12, 32'h34, 32'h77);
    next_cycle();
    checks++;
    if (ALU_res !== 32'h0 || WB_EN !== 1'b1 || MEM_R_EN !== 1'b1 || Dest !== 4'd2 ||
        ST_value !== 32'h77 || status !== 4'b1001) begin
      errors++; $display("FAIL undefined_cmd: got res=%h wb=%b r=%b dest=%0d st=%h nzcv=%b expected 0/1/1/2/77/1001",
                         ALU_res, WB_EN, MEM_R_EN, Dest, ST_value, status);
    end
  endtask

  task automatic test_mul();
    int busy_cycles;
    set_op(CMD_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h0);
    next_cycle();
    checks++;
    if (status !== 4'b1001) begin
      errors++; $display("FAIL overflow_status: got %b expected 1001", status);
    end
    set_op(CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 32'h0001_0003, 32'h0002_0005, 32'h0);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mul_busy_c0: got %b expected 1", busy);
    end
    busy_cycles = 1;
    for (int k = 1; k <= 32; k++) begin
      next_cycle();
      checks++;
      if (ALU_res !== 32'h0 || WB_EN !== 1'b0 || Dest !== 4'd0) begin
        errors++; $display("FAIL mul_bubble cycle %0d: got res=%h wb=%b dest=%0d expected 0/0/0",
                           k, ALU_res, WB_EN, Dest);
      end
      checks++;
      if (busy !== (k <= 31)) begin
        errors++; $display("FAIL mul_busy cycle %0d: got %b expected %b", k, busy, (k <= 31));
      end
      if (busy) busy_cycles++;
    end
    checks++;
    if (dbg_state !== S_MUL_RUN) begin
      errors++; $display("FAIL mul_state_c32: got %b expected %b", dbg_state, S_MUL_RUN);
    end
    checks++;
    if (busy_cycles !== 32) begin
      errors++; $display("FAIL mul_busy_count: got %0d expected 32", busy_cycles);
    end
    next_cycle();
    // Cycle 33: product visible, next instruction presented.
    checks++;
    if (ALU_res !== 32'h000B_000F || WB_EN !== 1'b1 || Dest !== 4'd5) begin
      errors++; $display("FAIL mul_product: got res=%h wb=%b dest=%0d expected 000b000f/1/5", ALU_res, WB_EN, Dest);
    end
    checks++;
    if (status !== 4'b0001) begin
      errors++; $display("FAIL mul_status: got %b expected 0001", status);
    end
    set_op(CMD_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 32'd1, 32'd2, 32'h0);
    #1;
    checks++;
    if (busy !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL mul_idle_c33: got busy=%b state=%b expected 0/0", busy, dbg_state);
    end
    next_cycle();
    checks++;
    if (ALU_res !== 32'd3 || Dest !== 4'd7 || status !== 4'b0001) begin
      errors++; $display("FAIL back_to_back: got res=%h dest=%0d nzcv=%b expected 3/7/0001", ALU_res, Dest, status);
    end
  endtask

  task automatic test_flush_mul();
    set_op(CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'd3, 32'd4, 32'h0);
    flush = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_mul_busy: got %b expected 0", busy);
    end
    next_cycle();
    checks++;
    if (ALU_res !== 32'h0 || WB_EN !== 1'b0 || Dest !== 4'd0 || dbg_state !== S_IDLE || status !== 4'b0001) begin
      errors++; $display("FAIL flush_mul_bubble: got res=%h wb=%b dest=%0d state=%b nzcv=%b expected 0/0/0/0/0001",
                         ALU_res, WB_EN, Dest, dbg_state, status);
    end
    set_op(CMD_SUB, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'd5, 32'd5, 32'h0);
    flush = 1'b1;
    next_cycle();
    checks++;
    if (ALU_res !== 32'h0 || MEM_R_EN !== 1'b0 || WB_EN !== 1'b0 || status !== 4'b0001) begin
      errors++; $display("FAIL flush_sub_bubble: got res=%h r=%b wb=%b nzcv=%b expected 0/0/0/0001",
                         ALU_res, MEM_R_EN, WB_EN, status);
    end
    flush = 1'b0;
  endtask

  task automatic test_str();
    set_op(CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h100, 32'h4, 32'hDEAD_BEEF);
    next_cycle();
    checks++;
    if (ALU_res !== 32'h104 || MEM_W_EN !== 1'b1 || ST_value !== 32'hDEAD_BEEF ||
        WB_EN !== 1'b0 || MEM_R_EN !== 1'b0) begin
      errors++; $display("FAIL str_addr: got res=%h w=%b st=%h wb=%b r=%b expected 104/1/deadbeef/0/0",
                         ALU_res, MEM_W_EN, ST_value, WB_EN, MEM_R_EN);
    end
  endtask

  task automatic test_reset_mid_mul();
    set_op(CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 32'd3, 32'd3, 32'h0);
    repeat (5) next_cycle();
    #2 rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if (busy !== 1'b0 || dbg_state !== S_IDLE || status !== 4'b0000 || ALU_res !== 32'h0) begin
      errors++; $display("FAIL reset_in_mul: got busy=%b state=%b nzcv=%b res=%h expected 0/0/0000/0",
                         busy, dbg_state, status, ALU_res);
    end
    next_cycle();
    rst = 1'b0;
    // Fresh multiply after the abandoned one: accumulator must start clean.
    set_op(CMD_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 32'd6, 32'd7, 32'h0);
    repeat (32) next_cycle();
    set_idle();
    next_cycle();
    checks++;
    if (ALU_res !== 32'd42 || Dest !== 4'd10 || status !== 4'b0000) begin
      errors++; $display("FAIL mul_after_reset: got res=%h dest=%0d nzcv=%b expected 2a/10/0000",
                         ALU_res, Dest, status);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_add_carry();
    test_sub_sbc();
    test_mul();
    test_flush_mul();
    test_str();
    test_logic();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
